// File: rtl/count_reg_initiator.sv
// count_reg_initiator: turns valid/ready commands into single-cycle register-bus accesses with write and incrementing read bursts
module count_reg_initiator #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              mod_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, RESP} state_t;
    state_t state, state_n;
    logic             write_r;
    logic [LEN_W-1:0] len_r;
    logic [2:0]       wcnt;
    logic             accept, last, step;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign last      = len_r == '0;
    assign step      = !last && ((state == ACCESS && write_r) || (state == RESP && rsp_ready));
    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_n;
    end
    // next state: writes stream one beat per cycle, reads wait for data and a consumed response
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ACCESS : IDLE;
            ACCESS:  state_n = !write_r ? WAIT_RD : last ? IDLE : ACCESS;
            WAIT_RD: state_n = wcnt == '0 ? RESP : WAIT_RD;
            RESP:    state_n = !rsp_ready ? RESP : last ? IDLE : ACCESS;
            default: state_n = IDLE;
        endcase
    end
    // registered bus strobes, beat address/length tracking, read latency timer and response capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mod_en    <= 1'b0;
            wr_en     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            write_r   <= 1'b0;
            len_r     <= '0;
            wcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            mod_en <= state_n == ACCESS;
            wr_en  <= state_n == ACCESS && (accept ? cmd_write : write_r);
            if (accept) begin
                addr    <= cmd_addr;
                wdata   <= cmd_wdata;
                write_r <= cmd_write;
                len_r   <= cmd_len;
            end else if (step) begin
                addr  <= addr + ADDR_W'(1);
                len_r <= len_r - LEN_W'(1);
            end
            wcnt <= state == WAIT_RD ? wcnt - 3'd1 : 3'(RD_LAT - 1);
            if (state == WAIT_RD && wcnt == '0) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata;
                rsp_last  <= last;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_last  <= 1'b0;
            end
        end
    end
endmodule
